// File: rtl/align_pkg.sv
// align_pkg: constants shared between the pass scheduler and the systolic
// array, plus the scheduler state encoding.
package align_pkg;

  localparam int unsigned ALIGN_N          = 64;
  localparam int unsigned ALIGN_LOG_N      = 6;
  localparam int unsigned ALIGN_BP_WIDTH   = 2;
  localparam int unsigned ALIGN_ADDR_WIDTH = 11;
  localparam int unsigned ALIGN_CALC_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_S   = 3'd1,
    STREAM_T = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/seq_fetch.sv
// seq_fetch: sequence-buffer reader. Issues `count` read addresses starting at
// `base` (counting down when DOWN=1), then registers the returned base one
// cycle after the synchronous-read data, so each beat appears two cycles after
// its address. Indices >= `limit` produce a zero base but still a valid beat.
// Ports:
//   clk, reset_i     clock, async active-low reset
//   go               load base/count and start issuing (one-cycle strobe)
//   base,count,limit start index, beat count, padding threshold
//   addr             buffer read address (index modulo 2^ADDR_WIDTH)
//   data             buffer read data (one cycle after addr)
//   last             current address is the final one of the burst
//   pending          an address is being issued or its read is in flight
//   beat_data/valid  registered output beat
module seq_fetch #(
  parameter int unsigned IDX_WIDTH  = 13,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned BP_WIDTH   = 2,
  parameter bit          DOWN       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  go,
  input  logic [IDX_WIDTH-1:0]  base,
  input  logic [IDX_WIDTH-1:0]  count,
  input  logic [IDX_WIDTH-1:0]  limit,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [BP_WIDTH-1:0]   data,
  output logic                  last,
  output logic                  pending,
  output logic [BP_WIDTH-1:0]   beat_data,
  output logic                  beat_valid
);

  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] remain;
  logic                 act;
  logic                 act_q;
  logic                 pad_q;

  assign addr    = idx[ADDR_WIDTH-1:0];
  assign last    = act && (remain == IDX_WIDTH'(1));
  assign pending = act || act_q;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      idx        <= '0;
      remain     <= '0;
      act        <= 1'b0;
      act_q      <= 1'b0;
      pad_q      <= 1'b0;
      beat_data  <= '0;
      beat_valid <= 1'b0;
    end else begin
      if (go) begin
        idx    <= base;
        remain <= count;
        act    <= 1'b1;
      end else if (act) begin
        remain <= remain - 1'b1;
        if (remain == IDX_WIDTH'(1)) begin
          act <= 1'b0;
        end else if (DOWN) begin
          idx <= idx - 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      // padding decision travels alongside the read so it lines up with data
      act_q      <= act;
      pad_q      <= act && (idx >= limit);
      beat_valid <= act_q;
      beat_data  <= (act_q && !pad_q) ? data : '0;
    end
  end

endmodule

// File: rtl/align_sched.sv
// align_sched: pass scheduler for the affine-gap systolic array. Splits the
// query into ceil(s_len/N) passes; each pass loads N query bases (highest index
// first), streams t_len target bases, then waits for the array to drain. The
// final drain latches the array's best score and traceback coordinates.
// Ports:
//   clk, reset_i               clock, async active-low reset
//   start, s_len, t_len        job request (sampled in IDLE only)
//   sched_busy, done, err      job status; err qualifies done
//   score, tb_x, tb_y          latched array result
//   s_addr/s_data, t_addr/t_data  query/target buffer (sync read)
//   arr_S, arr_T, arr_s_update, arr_valid, arr_ack, arr_new_seq, arr_PE_end
//                              array controls
//   arr_busy, arr_max, arr_tb_x, arr_tb_y  array status and result
module align_sched
  import align_pkg::*;
#(
  parameter int unsigned N             = ALIGN_N,
  parameter int unsigned LOG_N         = ALIGN_LOG_N,
  parameter int unsigned BP_WIDTH      = ALIGN_BP_WIDTH,
  parameter int unsigned ADDR_WIDTH    = ALIGN_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH     = 12,
  parameter int unsigned CALC_WIDTH    = ALIGN_CALC_WIDTH,
  parameter int unsigned DRAIN_TIMEOUT = 4095
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic [LEN_WIDTH-1:0]  t_len,
  output logic                  sched_busy,
  output logic                  done,
  output logic                  err,
  output logic [CALC_WIDTH-1:0] score,
  output logic [ADDR_WIDTH-1:0] tb_x,
  output logic [ADDR_WIDTH-1:0] tb_y,
  output logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [BP_WIDTH-1:0]   s_data,
  output logic [ADDR_WIDTH-1:0] t_addr,
  input  logic [BP_WIDTH-1:0]   t_data,
  output logic [BP_WIDTH-1:0]   arr_S,
  output logic [BP_WIDTH-1:0]   arr_T,
  output logic                  arr_s_update,
  output logic                  arr_valid,
  output logic                  arr_ack,
  output logic                  arr_new_seq,
  output logic [LOG_N-1:0]      arr_PE_end,
  input  logic                  arr_busy,
  input  logic [CALC_WIDTH-1:0] arr_max,
  input  logic [ADDR_WIDTH-1:0] arr_tb_x,
  input  logic [ADDR_WIDTH-1:0] arr_tb_y
);

  localparam int unsigned IW = LEN_WIDTH + 1;
  localparam int unsigned PW = IW - LOG_N;
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

  sched_state_t         state;
  logic [LEN_WIDTH-1:0] s_len_q;
  logic [LEN_WIDTH-1:0] t_len_q;
  logic [PW-1:0]        pass_q;
  logic [PW-1:0]        last_pass;
  logic                 seen_busy;
  logic [TW-1:0]        tmo;
  logic                 err_q;

  logic          zero_len;
  logic          more;
  logic          drain_end;
  logic          drain_tmo;
  logic          go_s;
  logic [PW-1:0] pass_next;
  logic [IW-1:0] s_base;
  logic [IW-1:0] npass_sum;
  logic          q_last, q_pending, t_last, t_pending;

  assign zero_len  = (s_len == '0) || (t_len == '0);
  assign more      = (pass_q != last_pass);
  assign drain_end = (state == DRAIN) && seen_busy && !arr_busy;
  assign drain_tmo = (state == DRAIN) && !seen_busy && !arr_busy &&
                     (tmo == TW'(DRAIN_TIMEOUT - 1));
  // the next pass's first fetch is launched on the same edge as the state
  // change so that addresses occupy exactly the LOAD_S cycles
  assign go_s      = ((state == IDLE) && start && !zero_len) || (drain_end && more);
  assign pass_next = (state == IDLE) ? '0 : pass_q + 1'b1;
  assign s_base    = {pass_next, {LOG_N{1'b1}}};
  assign npass_sum = IW'(s_len) + IW'(N - 1);

  assign sched_busy = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;

  seq_fetch #(
    .IDX_WIDTH (IW),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BP_WIDTH  (BP_WIDTH),
    .DOWN      (1'b1)
  ) u_q_fetch (
    .clk       (clk),
    .reset_i   (reset_i),
    .go        (go_s),
    .base      (s_base),
    .count     (IW'(N)),
    .limit     (IW'(s_len_q)),
    .addr      (s_addr),
    .data      (s_data),
    .last      (q_last),
    .pending   (q_pending),
    .beat_data (arr_S),
    .beat_valid(arr_s_update)
  );

  seq_fetch #(
    .IDX_WIDTH (IW),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BP_WIDTH  (BP_WIDTH),
    .DOWN      (1'b0)
  ) u_t_fetch (
    .clk       (clk),
    .reset_i   (reset_i),
    .go        (q_last),
    .base      ('0),
    .count     (IW'(t_len_q)),
    .limit     (IW'(t_len_q)),
    .addr      (t_addr),
    .data      (t_data),
    .last      (t_last),
    .pending   (t_pending),
    .beat_data (arr_T),
    .beat_valid(arr_valid)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      s_len_q   <= '0;
      t_len_q   <= '0;
      pass_q    <= '0;
      last_pass <= '0;
      seen_busy <= 1'b0;
      tmo       <= '0;
      err_q     <= 1'b0;
      score     <= '0;
      tb_x      <= '0;
      tb_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_len_q   <= s_len;
            t_len_q   <= t_len;
            pass_q    <= '0;
            last_pass <= npass_sum[IW-1:LOG_N] - 1'b1;
            if (zero_len) begin
              state <= DONE;
              err_q <= 1'b1;
            end else begin
              state <= LOAD_S;
            end
          end
        end
        LOAD_S: begin
          if (q_last) state <= STREAM_T;
        end
        STREAM_T: begin
          if (t_last) begin
            state     <= DRAIN;
            seen_busy <= 1'b0;
            tmo       <= '0;
          end
        end
        DRAIN: begin
          if (!seen_busy) begin
            if (arr_busy) begin
              seen_busy <= 1'b1;
            end else if (drain_tmo) begin
              state <= DONE;
              err_q <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end else if (!arr_busy) begin
            if (more) begin
              pass_q <= pass_q + 1'b1;
              state  <= LOAD_S;
            end else begin
              score <= arr_max;
              tb_x  <= arr_tb_x;
              tb_y  <= arr_tb_y;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ack spans from the first in-flight query read to the last target beat;
  // new_seq marks the single cycle where ack rises on pass 0
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      arr_ack     <= 1'b0;
      arr_new_seq <= 1'b0;
      arr_PE_end  <= '0;
    end else begin
      arr_ack     <= q_pending || t_pending;
      arr_new_seq <= (state == LOAD_S) && q_pending && !arr_ack && (pass_q == '0);
      if (state == LOAD_S) begin
        arr_PE_end <= (pass_q == last_pass) ? (s_len_q[LOG_N-1:0] - 1'b1)
                                            : LOG_N'(N - 1);
      end
    end
  end

endmodule

// File: tb/tb_align_sched.sv
// tb_align_sched: directed-vector bench for align_sched with sequence-buffer
// models and a simple array drain model.
module tb_align_sched;

  localparam int NPE = 64;
  localparam int TO  = 4095;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start;
  logic [11:0] s_len, t_len;
  logic        sched_busy, done, err;
  logic [15:0] score;
  logic [10:0] tb_x, tb_y, s_addr, t_addr;
  logic [1:0]  s_data, t_data, arr_S, arr_T;
  logic        arr_s_update, arr_valid, arr_ack, arr_new_seq;
  logic [5:0]  arr_PE_end;
  logic        arr_busy;
  logic [15:0] arr_max;
  logic [10:0] arr_tb_x, arr_tb_y;

  align_sched #(
    .N(64), .LOG_N(6), .BP_WIDTH(2), .ADDR_WIDTH(11), .LEN_WIDTH(12),
    .CALC_WIDTH(16), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .s_len(s_len), .t_len(t_len),
    .sched_busy(sched_busy), .done(done), .err(err), .score(score),
    .tb_x(tb_x), .tb_y(tb_y), .s_addr(s_addr), .s_data(s_data),
    .t_addr(t_addr), .t_data(t_data), .arr_S(arr_S), .arr_T(arr_T),
    .arr_s_update(arr_s_update), .arr_valid(arr_valid), .arr_ack(arr_ack),
    .arr_new_seq(arr_new_seq), .arr_PE_end(arr_PE_end), .arr_busy(arr_busy),
    .arr_max(arr_max), .arr_tb_x(arr_tb_x), .arr_tb_y(arr_tb_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // sequence buffers
  logic [1:0] smem [2048];
  logic [1:0] tmem [2048];
  always @(posedge clk) begin
    s_data <= smem[s_addr];
    t_data <= tmem[t_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // array drain model: busy rises 3 cycles after ack falls, lasts 4 cycles
  bit busy_en = 1'b1;
  int busy_fall_cyc = -1;
  always begin
    @(negedge arr_ack);
    if (busy_en && reset_i) begin
      repeat (3) @(posedge clk);
      #1 arr_busy = 1'b1;
      repeat (4) @(posedge clk);
      #1 arr_busy = 1'b0;
      busy_fall_cyc = cyc;
    end
  end

  // monitor
  logic [1:0] sq[$];
  logic [1:0] tq[$];
  logic [5:0] pe_q[$];
  int  ack_rises, ns_cnt, seq_bad, done_cnt, done_cyc, ack_fall_cyc, tog, su_run;
  bit  done_err;
  logic p_ack = 0, pp_ack = 0, p_su = 0, p_v = 0;
  logic [16:0] p_vec = '0;

  always @(negedge clk) begin
    if (arr_s_update) sq.push_back(arr_S);
    if (arr_valid) tq.push_back(arr_T);
    if (arr_ack && !p_ack) begin
      ack_rises++;
      pe_q.push_back(arr_PE_end);
      if (arr_s_update || arr_valid) seq_bad++;
    end
    if (arr_new_seq) begin
      ns_cnt++;
      if (!(arr_ack && !p_ack)) seq_bad++;
    end
    // first query beat must come exactly one cycle after ack rises
    if (arr_s_update && !p_su && !(p_ack && !pp_ack)) seq_bad++;
    if (arr_valid && !p_v && !p_su) seq_bad++;
    if (!arr_ack && p_ack) begin
      ack_fall_cyc = cyc;
      if (!p_v || arr_valid) seq_bad++;
    end
    if (!arr_ack && (arr_s_update || arr_valid)) seq_bad++;
    if (arr_s_update) su_run++;
    else begin
      if (p_su && su_run != NPE) seq_bad++;
      su_run = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
    if ({arr_ack, arr_s_update, arr_valid, arr_new_seq, arr_S, arr_T, arr_PE_end} != p_vec) tog++;
    p_vec  = {arr_ack, arr_s_update, arr_valid, arr_new_seq, arr_S, arr_T, arr_PE_end};
    pp_ack = p_ack;
    p_ack  = arr_ack;
    p_su   = arr_s_update;
    p_v    = arr_valid;
  end

  int start_cyc;
  logic [15:0] exp_max;
  logic [10:0] exp_x, exp_y;

  task automatic kick(input int sl, input int tl);
    @(posedge clk); #1;
    s_len = 12'(sl); t_len = 12'(tl); start = 1'b1;
    exp_max = 16'(16'hA000 + sl * 3 + tl);
    exp_x = 11'(sl + 5); exp_y = 11'(tl + 9);
    arr_max = exp_max; arr_tb_x = exp_x; arr_tb_y = exp_y;
    sq.delete(); tq.delete(); pe_q.delete();
    ack_rises = 0; ns_cnt = 0; seq_bad = 0; done_cnt = 0; done_cyc = -1;
    done_err = 0; tog = 0; su_run = 0;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    #1;
    if (!seen) check_val({tag, "_done_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int sl, input int tl, input bit exp_err);
    int np, bad, idx, e;
    np = (sl + NPE - 1) / NPE;
    check_val({tag, "_done_cnt"}, done_cnt, 1);
    check_val({tag, "_err"}, done_err, exp_err);
    check_val({tag, "_idle_after"}, sched_busy, 0);
    if (!exp_err) begin
      check_val({tag, "_done_lat"}, done_cyc - busy_fall_cyc, 1);
      check_val({tag, "_score"}, score, exp_max);
      check_val({tag, "_tb_x"}, tb_x, exp_x);
      check_val({tag, "_tb_y"}, tb_y, exp_y);
      check_val({tag, "_passes"}, ack_rises, np);
      check_val({tag, "_new_seq"}, ns_cnt, 1);
      check_val({tag, "_seq"}, seq_bad, 0);
      check_val({tag, "_s_beats"}, sq.size(), np * NPE);
      check_val({tag, "_t_beats"}, tq.size(), np * tl);
      bad = 0;
      for (int k = 0; k < sq.size(); k++) begin
        idx = (k / NPE) * NPE + NPE - 1 - (k % NPE);
        e = (idx < sl) ? int'(smem[idx]) : 0;
        if (int'(sq[k]) != e) bad++;
      end
      check_val({tag, "_s_data"}, bad, 0);
      bad = 0;
      for (int k = 0; k < tq.size(); k++) begin
        if (tq[k] != tmem[k % tl]) bad++;
      end
      check_val({tag, "_t_data"}, bad, 0);
      for (int p = 0; p < pe_q.size(); p++) begin
        e = (p == np - 1) ? ((sl - 1) % NPE) : NPE - 1;
        check_val({tag, "_pe_end"}, pe_q[p], e);
      end
    end
  endtask

  task automatic wait_sig_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (arr_valid) begin seen = 1; break; end
    end
    if (!seen) check_val({tag, "_valid_timeout"}, 0, 1);
  endtask

  function automatic int all_outs();
    return int'(|{sched_busy, done, err, score, tb_x, tb_y, s_addr, t_addr,
                  arr_S, arr_T, arr_s_update, arr_valid, arr_ack, arr_new_seq,
                  arr_PE_end});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      smem[i] = 2'((i * 5 + (i >> 3) + 1) % 4);
      tmem[i] = 2'((i * 3 + 2) % 4);
    end
    reset_i = 1'b0; start = 1'b0; s_len = '0; t_len = '0;
    arr_busy = 1'b0; arr_max = '0; arr_tb_x = '0; arr_tb_y = '0;
    #1;
    check_val("reset_outs", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;

    // single pass, full query
    kick(64, 10);
    wait_done("A", 600);
    verify("A", 64, 10, 1'b0);

    // three passes, last one zero-padded
    kick(130, 5);
    wait_done("B", 1000);
    verify("B", 130, 5, 1'b0);

    // zero-length job: done right after the accepting edge, array untouched
    kick(0, 7);
    wait_done("Z", 20);
    check_val("Z_err", done_err, 1);
    check_val("Z_done_cyc", done_cyc, start_cyc + 1);
    check_val("Z_done_cnt", done_cnt, 1);
    check_val("Z_toggles", tog, 0);

    // drain timeout: array never raises busy
    busy_en = 1'b0;
    kick(64, 1);
    wait_done("TO", 5000);
    verify("TO", 64, 1, 1'b1);
    check_val("TO_wait", done_cyc - ack_fall_cyc, TO - 2);
    busy_en = 1'b1;

    // start asserted mid-job must be ignored
    kick(64, 3);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; s_len = 12'd200; t_len = 12'd50;
    @(posedge clk); #1 start = 1'b0;
    wait_done("M", 600);
    verify("M", 64, 3, 1'b0);

    // reset during target streaming
    kick(64, 20);
    wait_sig_valid("R");
    #1 reset_i = 1'b0;
    #1 check_val("R_async_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_val("R_no_done", done_cnt, 0);
    check_val("R_idle", sched_busy, 0);

    // fresh job after reset
    kick(100, 4);
    wait_done("P", 800);
    verify("P", 100, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
